// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the block data memory
//
// Purpose: state/op enums, default geometry and counter width shared by
//          block_data_memory, mem_latency_counter and the cache controller.
// Ports:   none (package).
package mem_pkg;

  localparam int ADDR_W_DEF  = 6;
  localparam int DATA_W_DEF  = 32;
  localparam int BLOCK_BYTES = 4;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/mem_latency_counter.sv
// rtl/mem_latency_counter.sv - load/decrement latency counter with zero flag
//
// Purpose: counts down the service latency of a memory transaction.
// Ports:   clk_i   - clock, rising edge
//          rst_ni  - asynchronous active-low reset
//          load_i  - load LATENCY-1 (has priority over dec_i)
//          dec_i   - decrement request, saturates at 0
//          zero_o  - counter currently equals 0
module mem_latency_counter
  import mem_pkg::*;
#(
  parameter int LATENCY = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Decrement stops at zero, so the counter never wraps.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LOAD_VAL;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/block_data_memory.sv
// rtl/block_data_memory.sv - slow block backing store behind the cache controller
//
// Purpose: DEPTH x DATA_W block memory with a fixed LATENCY-cycle service
//          time and a BUSYWAIT handshake. LATENCY legal range is 1..15.
// Ports:   CLK       - clock, rising edge
//          RESET_N   - asynchronous active-low reset (clears every block)
//          READ      - read request level
//          WRITE     - write request level
//          ADDRESS   - block address
//          WRITEDATA - block to store
//          READDATA  - last block read, registered
//          BUSYWAIT  - request pending or in service
module block_data_memory
  import mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LATENCY = 5
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] WRITEDATA,
  output logic [DATA_W-1:0] READDATA,
  output logic              BUSYWAIT
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e            state_q;
  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic valid_req;
  logic accept;
  logic cnt_zero;

  // Both strobes high is illegal and treated as no request at all.
  assign valid_req = READ ^ WRITE;
  assign accept    = (state_q == IDLE) && valid_req;

  mem_latency_counter #(
    .LATENCY(LATENCY)
  ) u_lat_cnt (
    .clk_i (CLK),
    .rst_ni(RESET_N),
    .load_i(accept),
    .dec_i (state_q == BUSY),
    .zero_o(cnt_zero)
  );

  // In IDLE busywait follows the request combinationally so the requester
  // stalls in the same cycle it asks; held low while in reset.
  assign BUSYWAIT = RESET_N && ((state_q == BUSY) || accept);
  assign READDATA = rdata_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          // Request is captured here; later ADDRESS/WRITEDATA changes are ignored.
          if (valid_req) begin
            op_q    <= WRITE ? OP_WRITE : OP_READ;
            addr_q  <= ADDRESS;
            data_q  <= WRITEDATA;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_zero) begin
            if (op_q == OP_READ) begin
              rdata_q <= mem_q[addr_q];
            end else begin
              mem_q[addr_q] <= data_q;
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          // One request-blind cycle lets the requester drop its strobe.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_data_memory.sv
// tb/tb_block_data_memory.sv - self-checking bench for block_data_memory
module tb_block_data_memory;
  import mem_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [1:0]       rd;
  logic [1:0]       wr;
  logic [1:0][5:0]  ad;
  logic [1:0][31:0] wd;
  logic [1:0][31:0] rdo;
  logic [1:0]       bw;

  int               lat [2];
  logic [31:0]      mdl_rd [2];
  logic [31:0]      sb [$];
  int               pass_cnt;
  int               total;

  typedef struct {
    bit          is_wr;
    logic [5:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  block_data_memory #(.ADDR_W(6), .DATA_W(32), .LATENCY(5)) dut0 (
    .CLK(clk), .RESET_N(rst_n), .READ(rd[0]), .WRITE(wr[0]),
    .ADDRESS(ad[0]), .WRITEDATA(wd[0]), .READDATA(rdo[0]), .BUSYWAIT(bw[0])
  );

  block_data_memory #(.ADDR_W(6), .DATA_W(32), .LATENCY(1)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .READ(rd[1]), .WRITE(wr[1]),
    .ADDRESS(ad[1]), .WRITEDATA(wd[1]), .READDATA(rdo[1]), .BUSYWAIT(bw[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic pop_chk(input string name, input logic [31:0] act, output logic [31:0] e);
    if (sb.size() == 0) begin
      total++;
      e = 'x;
      $display("FAIL %s: scoreboard empty, got %h", name, act);
    end else begin
      e = sb.pop_front();
      chk(name, act, e);
    end
  endtask

  // One complete transaction on DUT w, checked for latency and result.
  task automatic txn(input int w, input bit is_wr, input logic [5:0] a,
                     input logic [31:0] d, input logic [31:0] exp);
    int cyc;
    logic [31:0] e;
    @(negedge clk);
    rd[w] = !is_wr;
    wr[w] = is_wr;
    ad[w] = a;
    wd[w] = d;
    if (!is_wr) sb.push_back(exp);
    #1 chk("busywait_same_cycle", {31'b0, bw[w]}, 32'd1);
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      if (!bw[w]) break;
      cyc++;
      if (is_wr) chk("rdata_hold_during_write", rdo[w], mdl_rd[w]);
    end
    chk("latency", cyc, lat[w]);
    rd[w] = 1'b0;
    wr[w] = 1'b0;
    if (!is_wr) begin
      pop_chk("read_data", rdo[w], e);
      mdl_rd[w] = e;
    end else begin
      chk("rdata_after_write", rdo[w], mdl_rd[w]);
    end
    @(negedge clk);
    #1 chk("idle_busywait_low", {31'b0, bw[w]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] e;
    pass_cnt  = 0;
    total     = 0;
    lat[0]    = 5;
    lat[1]    = 1;
    mdl_rd[0] = '0;
    mdl_rd[1] = '0;
    rd = '0; wr = '0; ad = '0; wd = '0;

    tbl[0] = '{1'b0, 6'h05, 32'h0,        32'h0};
    tbl[1] = '{1'b1, 6'h2A, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b0, 6'h2A, 32'h0,        32'hDEADBEEF};
    tbl[3] = '{1'b1, 6'h11, 32'h0BADF00D, 32'h0};
    tbl[4] = '{1'b0, 6'h00, 32'h0,        32'h0};
    tbl[5] = '{1'b0, 6'h11, 32'h0,        32'h0BADF00D};
    tbl[6] = '{1'b1, 6'h2A, 32'h11111111, 32'h0};
    tbl[7] = '{1'b0, 6'h2A, 32'h0,        32'h11111111};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busywait", {31'b0, bw[0]}, 32'd0);
    chk("reset_readdata", rdo[0], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busywait", {31'b0, bw[0]}, 32'd0);

    // Table-driven transactions
    for (int i = 0; i < 8; i++) begin
      txn(0, tbl[i].is_wr, tbl[i].a, tbl[i].d, tbl[i].exp);
    end

    // Illegal READ and WRITE together: ignored
    @(negedge clk);
    rd[0] = 1'b1; wr[0] = 1'b1; ad[0] = 6'h01; wd[0] = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      #1 chk("illegal_busywait", {31'b0, bw[0]}, 32'd0);
      @(negedge clk);
    end
    rd[0] = 1'b0; wr[0] = 1'b0;
    txn(0, 1'b0, 6'h01, 32'h0, 32'h0);

    // Reset in BUSY cycle 3 aborts the write
    @(negedge clk);
    wr[0] = 1'b1; ad[0] = 6'h10; wd[0] = 32'h12345678;
    repeat (3) @(negedge clk);
    chk("busy_before_reset", {31'b0, bw[0]}, 32'd1);
    rst_n = 1'b0;
    #1 chk("reset_mid_busy_busywait", {31'b0, bw[0]}, 32'd0);
    chk("reset_mid_busy_readdata", rdo[0], 32'h0);
    wr[0] = 1'b0;
    mdl_rd[0] = '0;
    mdl_rd[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(0, 1'b0, 6'h10, 32'h0, 32'h0);

    // READ held continuously: two back-to-back transactions
    txn(0, 1'b1, 6'h3F, 32'h77778888, 32'h0);
    @(negedge clk);
    rd[0] = 1'b1; ad[0] = 6'h3F;
    sb.push_back(32'h77778888);
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      if (!bw[0]) break;
      cyc++;
      if (cyc == 2) begin
        ad[0] = 6'h00;
        sb.push_back(32'h0);
      end
    end
    chk("held_first_latency", cyc, 5);
    pop_chk("held_first_data", rdo[0], e);
    @(negedge clk);
    chk("held_done_one_cycle", {31'b0, bw[0]}, 32'd1);
    cyc = 1;
    while (cyc < 40) begin
      @(negedge clk);
      if (!bw[0]) break;
      cyc++;
    end
    chk("held_second_high_cycles", cyc, 6);
    pop_chk("held_second_data", rdo[0], e);
    rd[0] = 1'b0;
    @(negedge clk);
    #1 chk("held_end_idle", {31'b0, bw[0]}, 32'd0);

    // LATENCY=1 instance
    txn(1, 1'b1, 6'h07, 32'hA5A5A5A5, 32'h0);
    txn(1, 1'b0, 6'h07, 32'h0, 32'hA5A5A5A5);

    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
